// File: rtl/softmax_sched_pkg.sv
// Shared types and constants for the softmax job scheduler.
//   sched_state_e : scheduler FSM states
//   job_desc_t    : (start_addr, end_addr) descriptor at the default address width
//   CompletedW    : width of the wrapping completion counter
package softmax_sched_pkg;

  localparam int unsigned AddrSizeDef = 8;
  localparam int unsigned CompletedW  = 16;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LAUNCH,
    RUN,
    ABORT
  } sched_state_e;

  typedef struct packed {
    logic [AddrSizeDef-1:0] start_addr;
    logic [AddrSizeDef-1:0] end_addr;
  } job_desc_t;

endpackage

// File: rtl/softmax_job_fifo.sv
// Synchronous descriptor FIFO for the softmax job scheduler.
//   clk, reset (sync, active-low)
//   push/wdata : write at tail (ignored when full)
//   pop/rdata  : rdata is the head entry; pop advances it (ignored when empty)
//   full, empty, count : occupancy status
module softmax_job_fifo #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam logic [IdxW:0] PtrOne = (IdxW + 1)'(1);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [IdxW:0]      wr_ptr_q, rd_ptr_q;
  logic [Width-1:0]   mem_q [Depth];
  logic               do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                   (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q[IdxW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IdxW-1:0]] <= wdata;
  end

endmodule

// File: rtl/softmax_job_scheduler.sv
// Sequences the softmax engine over queued (start_addr, end_addr) jobs.
//   clk, reset (sync, active-low)
//   job_valid/job_ready/job_start_addr/job_end_addr : descriptor push interface
//   timeout_limit : max RUN cycles per job, 0 disables
//   clear_err     : clears sticky error flags
//   sm_init/sm_start/sm_start_addr/sm_end_addr/sm_done : engine control
//   busy, job_done, jobs_completed, err_bad_range, err_timeout : status
module softmax_job_scheduler
  import softmax_sched_pkg::*;
#(
  parameter int unsigned ADDRSIZE = AddrSizeDef,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TMO_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [ADDRSIZE-1:0]   job_start_addr,
  input  logic [ADDRSIZE-1:0]   job_end_addr,
  input  logic [TMO_W-1:0]      timeout_limit,
  input  logic                  clear_err,
  output logic                  sm_init,
  output logic                  sm_start,
  output logic [ADDRSIZE-1:0]   sm_start_addr,
  output logic [ADDRSIZE-1:0]   sm_end_addr,
  input  logic                  sm_done,
  output logic                  busy,
  output logic                  job_done,
  output logic [CompletedW-1:0] jobs_completed,
  output logic                  err_bad_range,
  output logic                  err_timeout
);

  localparam int unsigned DescW = 2 * ADDRSIZE;
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam logic [TMO_W-1:0]      TmoOne  = TMO_W'(1);
  localparam logic [CompletedW-1:0] CompOne = CompletedW'(1);

  sched_state_e            state_q, state_d;
  logic                    in_reset_q;
  logic [ADDRSIZE-1:0]     start_addr_q, start_addr_d;
  logic [ADDRSIZE-1:0]     end_addr_q, end_addr_d;
  logic [TMO_W-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [CompletedW-1:0]   completed_q, completed_d;
  logic                    job_done_q, job_done_d;
  logic                    err_range_q, err_range_d;
  logic                    err_tmo_q, err_tmo_d;
  logic                    range_evt, tmo_evt;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0]         fifo_count;
  logic [DescW-1:0]        head;
  logic [ADDRSIZE-1:0]     head_start, head_end;

  assign head_start = head[DescW-1:ADDRSIZE];
  assign head_end   = head[ADDRSIZE-1:0];

  // in_reset_q keeps the engine in init and blocks pushes for the cycle after each reset edge.
  assign job_ready = ~in_reset_q & ~fifo_full;
  assign fifo_push = job_valid & job_ready;

  softmax_job_fifo #(
    .Width (DescW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata ({job_start_addr, job_end_addr}),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    tmo_cnt_d    = tmo_cnt_q;
    completed_d  = completed_q;
    job_done_d   = 1'b0;
    fifo_pop     = 1'b0;
    range_evt    = 1'b0;
    tmo_evt      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_end < head_start) begin
            range_evt = 1'b1;
          end else begin
            start_addr_d = head_start;
            end_addr_d   = head_end;
            state_d      = INIT;
          end
        end
      end
      INIT: state_d = LAUNCH;
      LAUNCH: begin
        tmo_cnt_d = '0;
        state_d   = RUN;
      end
      RUN: begin
        if (sm_done) begin
          job_done_d  = 1'b1;
          completed_d = completed_q + CompOne;
          state_d     = IDLE;
        end else if ((timeout_limit != '0) && (tmo_cnt_q == timeout_limit - TmoOne)) begin
          tmo_evt = 1'b1;
          state_d = ABORT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoOne;
        end
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new error event outranks a simultaneous clear.
    err_range_d = (err_range_q & ~clear_err) | range_evt;
    err_tmo_d   = (err_tmo_q & ~clear_err) | tmo_evt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      in_reset_q   <= 1'b1;
      start_addr_q <= '0;
      end_addr_q   <= '0;
      tmo_cnt_q    <= '0;
      completed_q  <= '0;
      job_done_q   <= 1'b0;
      err_range_q  <= 1'b0;
      err_tmo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_reset_q   <= 1'b0;
      start_addr_q <= start_addr_d;
      end_addr_q   <= end_addr_d;
      tmo_cnt_q    <= tmo_cnt_d;
      completed_q  <= completed_d;
      job_done_q   <= job_done_d;
      err_range_q  <= err_range_d;
      err_tmo_q    <= err_tmo_d;
    end
  end

  // ABORT re-inits the engine to kill the hung job.
  assign sm_init        = in_reset_q | (state_q == INIT) | (state_q == ABORT);
  assign sm_start       = (state_q == LAUNCH);
  assign sm_start_addr  = start_addr_q;
  assign sm_end_addr    = end_addr_q;
  assign busy           = (state_q != IDLE) | (fifo_count != '0);
  assign job_done       = job_done_q;
  assign jobs_completed = completed_q;
  assign err_bad_range  = err_range_q;
  assign err_timeout    = err_tmo_q;

endmodule
